red_track_filter: RTL

Temporal filter stage directly downstream of the red-object detector. Once per video frame it samples the detector's frame-end result: red row, red column and widest red run. It rejects frames with no real target, smooths the position with a shift-based exponential moving average, and tracks lock/loss over consecutive frames. It presents a clamped, registered position with a one-cycle update strobe to the overlay/game logic.

---
 rtl/red_track_pkg.sv | 16 +
 rtl/red_track_ema.sv | 61 ++++++
 rtl/red_track_filter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/red_track_pkg.sv
// Shared constants and FSM state type for the red-object tracking filter.
package red_track_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int DEF_ROW   = 240;
  localparam int DEF_COL   = 320;
  localparam int FRAC_BITS = 4;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    SETTLE,
    UPDATE
  } state_t;

endpackage

// File: rtl/red_track_ema.sv
// One axis of the tracker: fixed-point accumulator with snap/EMA-update/hold,
// followed by truncation and clamping to the visible coordinate range.
module red_track_ema
  import red_track_pkg::*;
#(
  parameter int W           = 9,
  parameter int MAX_VAL     = 479,
  parameter int DEF_VAL     = 240,
  parameter int ALPHA_SHIFT = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_en,
  input  logic         i_snap,
  input  logic         i_update,
  input  logic [W-1:0] i_sample,
  output logic [W-1:0] o_pos,
  output logic [W-1:0] o_posNext
);

  localparam int AW = W + FRAC_BITS;
  localparam logic [AW-1:0] L_ACC_RST = AW'(DEF_VAL << FRAC_BITS);
  localparam logic [W-1:0]  L_POS_RST = W'(DEF_VAL);
  localparam logic [W-1:0]  L_MAX     = W'(MAX_VAL);

  logic [AW-1:0]        r_acc;
  logic [W-1:0]         r_pos;
  logic [AW-1:0]        w_sampleFx;
  logic signed [AW:0]   w_diff;
  logic [AW-1:0]        w_accUpd;
  logic [AW-1:0]        w_accNext;
  logic [W-1:0]         w_trunc;

  assign w_sampleFx = {i_sample, {FRAC_BITS{1'b0}}};
  assign w_diff     = $signed({1'b0, w_sampleFx}) - $signed({1'b0, r_acc});
  // The arithmetic shift floors toward -inf, so downward moves also converge.
  assign w_accUpd   = AW'($signed({1'b0, r_acc}) + (w_diff >>> ALPHA_SHIFT));

  always_comb begin
    w_accNext = r_acc;
    if (i_snap)
      w_accNext = w_sampleFx;
    else if (i_update)
      w_accNext = w_accUpd;
  end

  assign w_trunc   = w_accNext[AW-1:FRAC_BITS];
  assign o_posNext = (w_trunc > L_MAX) ? L_MAX : w_trunc;
  assign o_pos     = r_pos;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc <= L_ACC_RST;
      r_pos <= L_POS_RST;
    end else if (i_en) begin
      r_acc <= w_accNext;
      r_pos <= o_posNext;
    end
  end

endmodule

// File: rtl/red_track_filter.sv
// Per-frame temporal filter for the red-object detector: frame-end detection,
// presence test, lock/loss tracking and EMA smoothing of row/column.
// Optional per-frame velocity outputs are built when RED_TRACK_VELOCITY_EN is defined.
module red_track_filter
  import red_track_pkg::*;
#(
  parameter int ALPHA_SHIFT = 2,
  parameter int MIN_WIDTH   = 8,
  parameter int LOST_FRAMES = 4,
  parameter int SETTLE_CYC  = 2
) (
  input  logic        iVgaClk,
  input  logic        reset,
  input  logic        iVgaVRequest,
  input  logic [8:0]  iRedRow,
  input  logic [9:0]  iRedCol,
  input  logic [9:0]  iRedWidth,
  output logic [8:0]  oRow,
  output logic [9:0]  oCol,
  output logic        oLocked,
  output logic        oValid,
  output logic [10:0] oVelRow,
  output logic [10:0] oVelCol
);

  localparam logic [2:0] L_SETTLE  = 3'(SETTLE_CYC);
  localparam logic [3:0] L_LOST    = 4'(LOST_FRAMES);
  localparam logic [9:0] L_MINW    = 10'(MIN_WIDTH);
  localparam logic [8:0] L_ROW_MAX = 9'(V_ACTIVE - 1);
  localparam logic [9:0] L_COL_LIM = 10'(H_ACTIVE);

  state_t     r_state;
  logic       r_vreqPrev;
  logic [2:0] r_settleCnt;
  logic [8:0] r_rowSample;
  logic [9:0] r_colSample;
  logic       r_present;
  logic       r_locked;
  logic [3:0] r_missCnt;
  logic       r_valid;

  logic       w_frameEnd;
  logic [3:0] w_missInc;
  logic       w_en;
  logic       w_snap;
  logic       w_upd;
  logic [8:0] w_rowNext;
  logic [9:0] w_colNext;

  assign w_frameEnd = r_vreqPrev && !iVgaVRequest;
  assign w_missInc  = (r_missCnt == 4'd15) ? 4'd15 : r_missCnt + 4'd1;
  assign w_en       = (r_state == UPDATE);
  assign w_snap     = r_present && !r_locked;
  assign w_upd      = r_present && r_locked;

  assign oLocked = r_locked;
  assign oValid  = r_valid;

  always_ff @(posedge iVgaClk) begin
    if (reset) begin
      r_state     <= WAIT_FRAME;
      r_vreqPrev  <= 1'b0;
      r_settleCnt <= 3'd0;
      r_rowSample <= 9'd0;
      r_colSample <= 10'd0;
      r_present   <= 1'b0;
      r_locked    <= 1'b0;
      r_missCnt   <= 4'd0;
      r_valid     <= 1'b0;
    end else begin
      r_vreqPrev <= iVgaVRequest;
      r_valid    <= 1'b0;
      case (r_state)
        WAIT_FRAME: begin
          if (w_frameEnd) begin
            r_state     <= SETTLE;
            r_settleCnt <= 3'd1;
          end
        end
        SETTLE: begin
          // A wrapped (underflowed) column means the target hugs the left edge.
          if (r_settleCnt == L_SETTLE) begin
            r_rowSample <= (iRedRow > L_ROW_MAX) ? L_ROW_MAX : iRedRow;
            r_colSample <= (iRedCol >= L_COL_LIM) ? 10'd0 : iRedCol;
            r_present   <= (iRedWidth >= L_MINW);
            r_state     <= UPDATE;
          end else begin
            r_settleCnt <= r_settleCnt + 3'd1;
          end
        end
        UPDATE: begin
          r_valid <= 1'b1;
          r_state <= WAIT_FRAME;
          if (r_present) begin
            r_locked  <= 1'b1;
            r_missCnt <= 4'd0;
          end else begin
            r_missCnt <= w_missInc;
            if (w_missInc >= L_LOST)
              r_locked <= 1'b0;
          end
        end
        default: r_state <= WAIT_FRAME;
      endcase
    end
  end

  red_track_ema #(
    .W(9), .MAX_VAL(V_ACTIVE - 1), .DEF_VAL(DEF_ROW), .ALPHA_SHIFT(ALPHA_SHIFT)
  ) u_rowEma (
    .i_clk(iVgaClk), .i_reset(reset), .i_en(w_en), .i_snap(w_snap), .i_update(w_upd),
    .i_sample(r_rowSample), .o_pos(oRow), .o_posNext(w_rowNext)
  );

  red_track_ema #(
    .W(10), .MAX_VAL(H_ACTIVE - 1), .DEF_VAL(DEF_COL), .ALPHA_SHIFT(ALPHA_SHIFT)
  ) u_colEma (
    .i_clk(iVgaClk), .i_reset(reset), .i_en(w_en), .i_snap(w_snap), .i_update(w_upd),
    .i_sample(r_colSample), .o_pos(oCol), .o_posNext(w_colNext)
  );

`ifdef RED_TRACK_VELOCITY_EN
  logic [10:0] r_velRow;
  logic [10:0] r_velCol;

  // Only a tracked-and-present frame has a meaningful delta; snap, loss and absence read as still.
  always_ff @(posedge iVgaClk) begin
    if (reset) begin
      r_velRow <= 11'd0;
      r_velCol <= 11'd0;
    end else if (w_en) begin
      r_velRow <= w_upd ? ({2'b00, w_rowNext} - {2'b00, oRow}) : 11'd0;
      r_velCol <= w_upd ? ({1'b0, w_colNext} - {1'b0, oCol}) : 11'd0;
    end
  end

  assign oVelRow = r_velRow;
  assign oVelCol = r_velCol;
`else
  logic w_unusedPosNext;
  assign w_unusedPosNext = ^{w_rowNext, w_colNext};
  assign oVelRow = 11'd0;
  assign oVelCol = 11'd0;
`endif

endmodule
